// File: rtl/aq_djpeg_marker_pkg.sv
// aq_djpeg_marker_pkg: marker codes, parser state encoding and marker classification helper
package aq_djpeg_marker_pkg;
  localparam logic [7:0] M_SOI  = 8'hD8;
  localparam logic [7:0] M_EOI  = 8'hD9;
  localparam logic [7:0] M_SOF0 = 8'hC0;
  localparam logic [7:0] M_DHT  = 8'hC4;
  localparam logic [7:0] M_DQT  = 8'hDB;
  localparam logic [7:0] M_DRI  = 8'hDD;
  localparam logic [7:0] M_SOS  = 8'hDA;
  typedef enum logic [4:0] {
    S_IDLE, S_SOI, S_MARKER, S_LENGTH, S_SKIP, S_SOS_SKIP,
    S_DQT_HDR, S_DQT_DATA, S_DQT_SKIP,
    S_DHT_HDR, S_DHT_LEN, S_DHT_SYM,
    S_SOF_P, S_SOF_Y, S_SOF_X, S_SOF_NF, S_SOF_COMP,
    S_DRI, S_IMAGE, S_ERROR
  } state_e;
  // C4 (DHT), C8 (JPG) and CC (DAC) share the Cx range but are not frame headers
  function automatic logic is_sofn(input logic [7:0] m);
    return m[7:4] == 4'hC && m != M_SOF0 && m != M_DHT && m != 8'hC8 && m != 8'hCC;
  endfunction
endpackage

// File: rtl/aq_djpeg_marker_seg_cnt.sv
// aq_djpeg_marker_seg_cnt: segment Remain counter (load len-2 clamped at 0, decrement by 1 or 2, zero flags)
//   clk, rst (async active-low), load_i/len_i: load from length field, dec1_i/dec2_i: byte/word consumed,
//   zero_o: Remain==0, lt2_o: Remain<2 (not enough for a word)
module aq_djpeg_marker_seg_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [15:0] len_i,
  input  logic        dec1_i,
  input  logic        dec2_i,
  output logic        zero_o,
  output logic        lt2_o
);
  logic [15:0] remain_q, remain_d;
  always_comb
    remain_d = load_i ? (len_i < 16'd2 ? 16'd0 : len_i - 16'd2) :
               dec2_i ? remain_q - 16'd2 :
               dec1_i ? remain_q - 16'd1 : remain_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) remain_q <= '0;
    else remain_q <= remain_d;
  assign zero_o = remain_q == 16'd0;
  assign lt2_o  = remain_q < 16'd2;
endmodule

// File: rtl/aq_djpeg_marker.sv
// aq_djpeg_marker: JPEG header/marker parser feeding quant/Huffman table RAMs ahead of entropy decode
//   In : clk, rst (async active-low), DataIn[31:0] window (next byte in [31:24]), DataInEnable,
//        DataInEnd (EOI seen in image data), DecodeIdle (back-end drained)
//   Out: UseByte/UseWord consume pulses, ImageEnable, ProcessIdle,
//        DqtEnable/DqtTable/DqtCount/DqtData, DhtEnable/DhtTable/DhtMode/DhtCount/DhtData,
//        ImageWidth, ImageHeight, CompNum, SampleY, RestartInterval, Error
//   Build option AQ_DJPEG_MARKER_ERR_EN: unsupported/malformed streams lock into a sticky Error state
//   instead of being skipped or truncated.
module aq_djpeg_marker
  import aq_djpeg_marker_pkg::*;
#(
  parameter int COMP_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] DataIn,
  input  logic        DataInEnable,
  input  logic        DataInEnd,
  input  logic        DecodeIdle,
  output logic        UseByte,
  output logic        UseWord,
  output logic        ImageEnable,
  output logic        ProcessIdle,
  output logic        DqtEnable,
  output logic [1:0]  DqtTable,
  output logic [5:0]  DqtCount,
  output logic [7:0]  DqtData,
  output logic        DhtEnable,
  output logic [1:0]  DhtTable,
  output logic        DhtMode,
  output logic [7:0]  DhtCount,
  output logic [7:0]  DhtData,
  output logic [15:0] ImageWidth,
  output logic [15:0] ImageHeight,
  output logic [1:0]  CompNum,
  output logic [7:0]  SampleY,
  output logic [15:0] RestartInterval,
  output logic        Error
);
`ifdef AQ_DJPEG_MARKER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [7:0] CMAX = 8'(COMP_MAX);
  localparam state_e TRUNC = ERR_EN ? S_ERROR : S_MARKER;
  state_e state_q, state_d;
  logic use_byte_q, use_word_q, dqt_en_q, dht_en_q, dht_mode_q, dht_mode_d;
  logic ub, uw, dqt_we, dht_we, ld, zero, lt2, act, seg;
  logic [7:0] wr_cnt_q, wr_cnt_d, wr_data_q, wr_data_d, marker_q, marker_d;
  logic [7:0] nf_q, nf_d, sy_q, sy_d;
  logic [9:0] idx_q, idx_d;
  logic [8:0] sum_q, sum_d;
  logic [1:0] tq_q, tq_d, dht_tbl_q, dht_tbl_d, comp_q, comp_d;
  logic [15:0] width_q, width_d, height_q, height_d, ri_q, ri_d;
  logic [7:0] b0, b1;
  logic [15:0] w;
  logic unused;
  assign unused = ^DataIn[15:0];
  assign b0 = DataIn[31:24];
  assign b1 = DataIn[23:16];
  assign w  = DataIn[31:16];
  // the window stays stale while our own Use* pulse is still outstanding
  assign act = DataInEnable && !use_byte_q && !use_word_q;
  assign seg = !(state_q inside {S_SOI, S_MARKER, S_LENGTH});
  aq_djpeg_marker_seg_cnt u_seg_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (ld),
    .len_i  (w),
    .dec1_i (ub && seg),
    .dec2_i (uw && seg),
    .zero_o (zero),
    .lt2_o  (lt2)
  );
  always_comb begin
    state_d = state_q;
    ub = 1'b0;
    uw = 1'b0;
    ld = 1'b0;
    dqt_we = 1'b0;
    dht_we = 1'b0;
    dht_mode_d = dht_mode_q;
    wr_cnt_d = wr_cnt_q;
    wr_data_d = wr_data_q;
    idx_d = idx_q;
    marker_d = marker_q;
    tq_d = tq_q;
    dht_tbl_d = dht_tbl_q;
    sum_d = sum_q;
    nf_d = nf_q;
    comp_d = comp_q;
    width_d = width_q;
    height_d = height_q;
    sy_d = sy_q;
    ri_d = ri_q;
    case (state_q)
      S_IDLE: state_d = DataInEnable ? S_SOI : S_IDLE;
      S_SOI: if (act) begin
        if (w == {8'hFF, M_SOI}) begin
          uw = 1'b1;
          ri_d = '0;
          state_d = S_MARKER;
        end else ub = 1'b1;
      end
      S_MARKER: if (act) begin
        // non-FF garbage and FF fill bytes are dropped one at a time
        if (b0 != 8'hFF || b1 == 8'hFF) ub = 1'b1;
        else begin
          uw = 1'b1;
          marker_d = b1;
          state_d = b1 == M_EOI ? S_IDLE : S_LENGTH;
        end
      end
      S_LENGTH: if (act) begin
        uw = 1'b1;
        ld = 1'b1;
        state_d = marker_q == M_DQT  ? S_DQT_HDR :
                  marker_q == M_DHT  ? S_DHT_HDR :
                  marker_q == M_SOF0 ? S_SOF_P :
                  marker_q == M_DRI  ? S_DRI :
                  marker_q == M_SOS  ? S_SOS_SKIP :
                  (ERR_EN && is_sofn(marker_q)) ? S_ERROR : S_SKIP;
      end
      S_SKIP, S_SOS_SKIP: begin
        if (zero) state_d = state_q == S_SKIP ? S_MARKER : S_IMAGE;
        else ub = act;
      end
      S_DQT_HDR: begin
        if (zero) state_d = S_MARKER;
        else if (act) begin
          ub = 1'b1;
          tq_d = b0[1:0];
          idx_d = '0;
          state_d = b0[7:4] == 4'd0 ? S_DQT_DATA : ERR_EN ? S_ERROR : S_DQT_SKIP;
        end
      end
      S_DQT_DATA: begin
        if (zero) state_d = TRUNC;
        else if (act) begin
          ub = 1'b1;
          dqt_we = 1'b1;
          wr_cnt_d = idx_q[7:0];
          wr_data_d = b0;
          idx_d = idx_q + 10'd1;
          if (idx_q == 10'd63) state_d = S_DQT_HDR;
        end
      end
      S_DQT_SKIP: begin
        if (zero) state_d = TRUNC;
        else if (act) begin
          ub = 1'b1;
          idx_d = idx_q + 10'd1;
          if (idx_q == 10'd127) state_d = S_DQT_HDR;
        end
      end
      S_DHT_HDR: begin
        if (zero) state_d = S_MARKER;
        else if (act) begin
          ub = 1'b1;
          dht_tbl_d = {b0[4], b0[0]};
          idx_d = '0;
          sum_d = '0;
          state_d = S_DHT_LEN;
        end
      end
      S_DHT_LEN: begin
        if (zero) state_d = TRUNC;
        else if (act) begin
          ub = 1'b1;
          dht_we = 1'b1;
          dht_mode_d = 1'b0;
          wr_cnt_d = idx_q[7:0];
          wr_data_d = b0;
          sum_d = sum_q + {1'b0, b0};
          idx_d = idx_q + 10'd1;
          if (idx_q == 10'd15) begin
            idx_d = '0;
            state_d = (ERR_EN && sum_d > 9'd162) ? S_ERROR : sum_d == 9'd0 ? S_DHT_HDR : S_DHT_SYM;
          end
        end
      end
      S_DHT_SYM: begin
        if (zero) state_d = TRUNC;
        else if (act) begin
          ub = 1'b1;
          dht_we = 1'b1;
          dht_mode_d = 1'b1;
          wr_cnt_d = idx_q[7:0];
          wr_data_d = b0;
          idx_d = idx_q + 10'd1;
          if (idx_q + 10'd1 == {1'b0, sum_q}) state_d = S_DHT_HDR;
        end
      end
      S_SOF_P: begin
        if (zero) state_d = TRUNC;
        else if (act) begin
          ub = 1'b1;
          state_d = S_SOF_Y;
        end
      end
      S_SOF_Y: begin
        if (lt2) state_d = TRUNC;
        else if (act) begin
          uw = 1'b1;
          height_d = w;
          state_d = S_SOF_X;
        end
      end
      S_SOF_X: begin
        if (lt2) state_d = TRUNC;
        else if (act) begin
          uw = 1'b1;
          width_d = w;
          state_d = S_SOF_NF;
        end
      end
      S_SOF_NF: begin
        if (zero) state_d = TRUNC;
        else if (act) begin
          ub = 1'b1;
          nf_d = b0;
          comp_d = b0 > CMAX ? CMAX[1:0] : b0[1:0];
          idx_d = '0;
          state_d = (ERR_EN && b0 > CMAX) ? S_ERROR : b0 == 8'd0 ? S_SKIP : S_SOF_COMP;
        end
      end
      S_SOF_COMP: begin
        if (zero) state_d = TRUNC;
        else if (act) begin
          // 3 bytes per component {C, HV, Tq}; byte 1 is component 1's sampling factors
          ub = 1'b1;
          sy_d = idx_q == 10'd1 ? b0 : sy_q;
          idx_d = idx_q + 10'd1;
          if (idx_q + 10'd1 == 10'(nf_q) * 10'd3) state_d = S_SKIP;
        end
      end
      S_DRI: begin
        if (lt2) state_d = TRUNC;
        else if (act) begin
          uw = 1'b1;
          ri_d = w;
          state_d = S_SKIP;
        end
      end
      S_IMAGE: state_d = (DataInEnd && DecodeIdle) ? S_IDLE : S_IMAGE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      use_byte_q <= 1'b0;
      use_word_q <= 1'b0;
      dqt_en_q <= 1'b0;
      dht_en_q <= 1'b0;
      dht_mode_q <= 1'b0;
      wr_cnt_q <= '0;
      wr_data_q <= '0;
      idx_q <= '0;
      marker_q <= '0;
      tq_q <= '0;
      dht_tbl_q <= '0;
      sum_q <= '0;
      nf_q <= '0;
      comp_q <= '0;
      width_q <= '0;
      height_q <= '0;
      sy_q <= '0;
      ri_q <= '0;
    end else begin
      state_q <= state_d;
      use_byte_q <= ub;
      use_word_q <= uw;
      dqt_en_q <= dqt_we;
      dht_en_q <= dht_we;
      dht_mode_q <= dht_mode_d;
      wr_cnt_q <= wr_cnt_d;
      wr_data_q <= wr_data_d;
      idx_q <= idx_d;
      marker_q <= marker_d;
      tq_q <= tq_d;
      dht_tbl_q <= dht_tbl_d;
      sum_q <= sum_d;
      nf_q <= nf_d;
      comp_q <= comp_d;
      width_q <= width_d;
      height_q <= height_d;
      sy_q <= sy_d;
      ri_q <= ri_d;
    end
  assign UseByte = use_byte_q;
  assign UseWord = use_word_q;
  assign ImageEnable = state_q == S_IMAGE;
  assign ProcessIdle = state_q == S_IDLE;
  assign DqtEnable = dqt_en_q;
  assign DqtTable = tq_q;
  assign DqtCount = wr_cnt_q[5:0];
  assign DqtData = wr_data_q;
  assign DhtEnable = dht_en_q;
  assign DhtTable = dht_tbl_q;
  assign DhtMode = dht_mode_q;
  assign DhtCount = wr_cnt_q;
  assign DhtData = wr_data_q;
  assign ImageWidth = width_q;
  assign ImageHeight = height_q;
  assign CompNum = comp_q;
  assign SampleY = sy_q;
  assign RestartInterval = ri_q;
`ifdef AQ_DJPEG_MARKER_ERR_EN
  assign Error = state_q == S_ERROR;
`else
  assign Error = 1'b0;
`endif
endmodule
